// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB register bank.
// Build option: OPB_REG_BANK_SHADOW_EN selects shadowed writes with a commit word.
package opb_reg_pkg;

  localparam int OPB_BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    HOLD
  } state_e;

  // OPB numbers bits MSB-first; registers are LSB-first.
  function automatic logic [31:0] opb2reg(
    input logic [0:31] d
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = d[i];
    end
    return r;
  endfunction

  // BE[0] covers DBus[0:7], i.e. register byte 3.
  function automatic logic [OPB_BE_W-1:0] be2lane(
    input logic [0:OPB_BE_W-1] be
  );
    logic [OPB_BE_W-1:0] l;
    for (int i = 0; i < OPB_BE_W; i++) begin
      l[OPB_BE_W-1-i] = be[i];
    end
    return l;
  endfunction

  function automatic logic [31:0] merge_bytes(
    input logic [31:0]         old_v,
    input logic [31:0]         new_v,
    input logic [OPB_BE_W-1:0] lane
  );
    logic [31:0] r;
    r = old_v;
    for (int j = 0; j < OPB_BE_W; j++) begin
      if (lane[j]) r[8*j+:8] = new_v[8*j+:8];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_reg_cell.sv
// One writable 32-bit register with byte lanes and update strobe.
// Build option: OPB_REG_BANK_SHADOW_EN adds a shadow copy and dirty flag.
module opb_reg_cell
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_i,
  input  logic                commit_i,
  input  logic [OPB_BE_W-1:0] be_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         q_o,
  output logic [31:0]         rd_o,
  output logic                dirty_o,
  output logic                stb_o
);

  logic [31:0] q_q, q_d;
  logic        stb_q, stb_d;

`ifdef OPB_REG_BANK_SHADOW_EN
  logic [31:0] sh_q, sh_d;
  logic        dirty_q, dirty_d;

  always_comb begin
    q_d     = q_q;
    sh_d    = sh_q;
    dirty_d = dirty_q;
    stb_d   = 1'b0;
    if (wr_i && |be_i) begin
      sh_d    = merge_bytes(sh_q, wdata_i, be_i);
      dirty_d = 1'b1;
    end else if (commit_i && dirty_q) begin
      q_d     = sh_q;
      stb_d   = 1'b1;
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q    <= RESET_VAL;
      dirty_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_o    = sh_q;
  assign dirty_o = dirty_q;
`else
  logic unused_commit;
  assign unused_commit = commit_i;

  always_comb begin
    q_d   = q_q;
    stb_d = 1'b0;
    if (wr_i && |be_i) begin
      q_d   = merge_bytes(q_q, wdata_i, be_i);
      stb_d = 1'b1;
    end
  end

  assign rd_o    = q_q;
  assign dirty_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= RESET_VAL;
      stb_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      stb_q <= stb_d;
    end
  end

  assign q_o   = q_q;
  assign stb_o = stb_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of software registers between PPC and user logic.
// Build option: OPB_REG_BANK_SHADOW_EN (shadowed writes, commit word at index C_NUM_REGS).
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_4000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_40FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RO_MASK    = 32'h0,
  parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:OPB_BE_W-1]          OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_xferAck,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]     user_data_out,
  input  logic [C_NUM_REGS*32-1:0]     user_data_in,
  output logic [C_NUM_REGS-1:0]        user_wr_stb
);

  localparam logic [C_OPB_AWIDTH-1:0] BASE = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [C_OPB_AWIDTH-1:0] HIGH = C_HIGHADDR[C_OPB_AWIDTH-1:0];

  state_e                  state_q;
  logic                    ack_q, err_q, cmt_q;
  logic [31:0]             dbus_q, wd_q;
  logic [OPB_BE_W-1:0]     be_q;
  logic [C_NUM_REGS-1:0]   wsel_q;

  logic [C_OPB_AWIDTH-1:0] addr, idx;
  logic                    hit, is_reg, is_cmt, ro_c, err_c, cmt_c;
  logic [31:0]             word_c, rdata_c, dirty_ext;
  logic [C_NUM_REGS-1:0]   sel_c, wsel_c, dirty;
  logic [31:0]             rd_w [C_NUM_REGS];
  logic                    ack_st;
  logic                    unused_ok;

  assign unused_ok = ^{OPB_seqAddr, user_data_in};

  assign addr      = OPB_ABus;
  assign idx       = (addr - BASE) >> 2;
  assign hit       = OPB_select && addr >= BASE && addr <= HIGH;
  assign dirty_ext = 32'(dirty);
  assign ack_st    = state_q == ACK;

`ifdef OPB_REG_BANK_SHADOW_EN
  assign is_cmt = idx == C_OPB_AWIDTH'(C_NUM_REGS);
`else
  assign is_cmt = 1'b0;
`endif

  always_comb begin
    sel_c  = '0;
    ro_c   = 1'b0;
    word_c = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (idx == C_OPB_AWIDTH'(k)) begin
        sel_c[k] = 1'b1;
        ro_c     = C_RO_MASK[k];
        word_c   = rd_w[k];
      end
    end
    is_reg  = |sel_c;
    err_c   = is_reg ? (ro_c && !OPB_RNW) : !is_cmt;
    rdata_c = '0;
    if (OPB_RNW && !err_c) rdata_c = is_reg ? word_c : dirty_ext;
    wsel_c  = (!OPB_RNW && !err_c) ? sel_c : '0;
    cmt_c   = !OPB_RNW && is_cmt && |OPB_BE;
  end

  // Request is captured on the hit edge; the write lands at the end of ACK.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dbus_q  <= '0;
      wsel_q  <= '0;
      cmt_q   <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dbus_q <= '0;
      wsel_q <= '0;
      cmt_q  <= 1'b0;
      unique case (state_q)
        IDLE: if (hit) begin
          state_q <= ACK;
          ack_q   <= 1'b1;
          err_q   <= err_c;
          dbus_q  <= rdata_c;
          wsel_q  <= wsel_c;
          cmt_q   <= cmt_c;
          be_q    <= be2lane(OPB_BE);
          wd_q    <= opb2reg(OPB_DBus);
        end
        ACK:     state_q <= OPB_select ? HOLD : IDLE;
        HOLD:    if (!OPB_select) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg
    if (C_RO_MASK[k]) begin : g_ro
      assign user_data_out[32*k+:32] = '0;
      assign rd_w[k]                 = user_data_in[32*k+:32];
      assign dirty[k]                = 1'b0;
      assign user_wr_stb[k]          = 1'b0;
    end else begin : g_rw
      opb_reg_cell #(
        .RESET_VAL(C_RESET_VAL)
      ) u_cell (
        .clk_i   (OPB_Clk),
        .rst_ni  (OPB_Rst_n),
        .wr_i    (ack_st && wsel_q[k]),
        .commit_i(ack_st && cmt_q),
        .be_i    (be_q),
        .wdata_i (wd_q),
        .q_o     (user_data_out[32*k+:32]),
        .rd_o    (rd_w[k]),
        .dirty_o (dirty[k]),
        .stb_o   (user_wr_stb[k])
      );
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = err_q;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Scoreboard bench for the OPB register bank: directed and random transfers.
// Model follows OPB_REG_BANK_SHADOW_EN when defined.
module tb_opb_register_bank_ppc2simulink;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0100_4000;
`ifdef OPB_REG_BANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:31]      abus, wdbus, sl_dbus;
  logic [0:3]       be;
  logic             rnw, sel, seq;
  logic             xack, eack, retry, tout;
  logic [N*32-1:0]  udo, udi;
  logic [N-1:0]     stb;

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS(N),
    .C_RO_MASK (32'h1)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (wdbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (xack),
    .Sl_errAck    (eack),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .user_data_out(udo),
    .user_data_in (udi),
    .user_wr_stb  (stb)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
  } ack_t;

  typedef struct {
    logic [N-1:0]    mask;
    logic [N*32-1:0] out;
  } stb_t;

  ack_t        ackq[$];
  stb_t        stbq[$];
  logic [31:0] mreg [N];
  logic [31:0] msh  [N];
  logic [N-1:0] mdirty;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [N*32-1:0] snap();
    logic [N*32-1:0] s;
    s = '0;
    for (int k = 1; k < N; k++) s[32*k+:32] = mreg[k];
    return s;
  endfunction

  // OPB lane i carries register bits 31-8i down to 24-8i.
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [0:3] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r[31-8*i -: 8] = d[31-8*i -: 8];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    ack_t a;
    stb_t s;
    if (rst_n) begin
      chk("retry_tout", {retry, tout}, 0);
      if (xack) begin
        if (ackq.size() == 0) chk("spurious_ack", 1, 0);
        else begin
          a = ackq.pop_front();
          chk("errAck", eack, a.err);
          chk("rdata", sl_dbus, a.data);
        end
      end else begin
        chk("idle_bus", {eack, sl_dbus}, 0);
      end
      if (stb != '0) begin
        if (stbq.size() == 0) chk("spurious_stb", stb, 0);
        else begin
          s = stbq.pop_front();
          chk("stb_mask", stb, s.mask);
          chk("user_data_out", udo, s.out);
        end
      end
    end
  end

  task automatic xfer(int k, bit r, logic [31:0] d, logic [0:3] b, int hold);
    logic [31:0] rd;
    logic [31:0] m;
    bit          err;
    bit          got;
    int          acks;
    rd  = '0;
    err = 1'b0;
    if (k < N) begin
      if (r) rd = (k == 0) ? udi[31:0] : (SHADOW ? msh[k] : mreg[k]);
      else if (k == 0) err = 1'b1;
      else if (b != 0) begin
        if (SHADOW) begin
          msh[k]    = merge(msh[k], d, b);
          mdirty[k] = 1'b1;
        end else begin
          mreg[k] = merge(mreg[k], d, b);
          stbq.push_back('{mask: N'(1) << k, out: snap()});
        end
      end
    end else if (SHADOW && k == N) begin
      if (r) rd = 32'(mdirty);
      else if (b != 0 && mdirty != 0) begin
        for (int j = 0; j < N; j++) if (mdirty[j]) mreg[j] = msh[j];
        stbq.push_back('{mask: mdirty, out: snap()});
        mdirty = '0;
      end
    end else err = 1'b1;
    ackq.push_back('{err: err, data: rd});

    @(negedge clk);
    abus  = BASE + 32'(4 * k);
    rnw   = r;
    wdbus = d;
    be    = b;
    sel   = 1'b1;
    got   = 1'b0;
    acks  = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (xack) begin
        got = 1'b1;
        acks++;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      if (ackq.size() != 0) void'(ackq.pop_front());
    end
    repeat (1 + hold) begin
      @(negedge clk);
      if (xack) acks++;
    end
    if (got) chk("ack_count", acks, 1);
    sel = 1'b0;
    rnw = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    abus   = '0;
    wdbus  = '0;
    be     = '0;
    rnw    = 1'b1;
    sel    = 1'b0;
    seq    = 1'b0;
    udi    = '0;
    mdirty = '0;
    for (int k = 0; k < N; k++) begin
      mreg[k] = '0;
      msh[k]  = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack", {xack, eack, stb}, 0);
    chk("rst_dbus", sl_dbus, 0);
    chk("rst_udo", udo, 0);
    rst_n = 1'b1;

    for (int k = 0; k < N; k++) xfer(k, 1'b1, '0, 4'b0000, 0);
    xfer(1, 1'b0, 32'hDEAD_BEEF, 4'b1111, 0);
    xfer(2, 1'b0, 32'h1122_3344, 4'b0100, 0);
    if (!SHADOW) chk("byte_lane", udo[95:64], 32'h0022_0000);
    xfer(2, 1'b1, '0, 4'b0000, 0);
    udi[31:0] = 32'hCAFE_0001;
    xfer(0, 1'b1, '0, 4'b0000, 0);
    xfer(0, 1'b0, 32'h1234_5678, 4'b1111, 0);
    xfer(32, 1'b1, '0, 4'b0000, 4);
    xfer(3, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1);
    xfer(1, 1'b0, 32'hA5A5_0101, 4'b1111, 0);
    xfer(3, 1'b0, 32'h5A5A_0303, 4'b1111, 0);
    chk("udo_before_commit", udo, snap());
    xfer(N, 1'b1, '0, 4'b0000, 0);
    xfer(N, 1'b0, '0, 4'b1111, 0);
    xfer(N, 1'b0, '0, 4'b1111, 0);

    for (int i = 0; i < 80; i++) begin
      udi = {$urandom, $urandom, $urandom, $urandom};
      xfer($urandom_range(0, N + 1), 1'($urandom), $urandom,
           4'($urandom), $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    chk("ackq_empty", ackq.size(), 0);
    chk("stbq_empty", stbq.size(), 0);
    chk("udo_final", udo, snap());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
